// File: rtl/hex_word_latch.sv
// hex_word_latch
// Holding register and display-control stage ahead of four 7-segment
// decoders. Captures a 16-bit word on an accepted load and presents it as
// four nibbles. Produces per-digit blank requests for leading-zero
// suppression and for a prescaled blink. A set Blank bit means the
// downstream decoder turns that digit fully off.
//
// BLINK_DIV is the number of clock cycles in one blink half-period. It must
// be at least 2.
module hex_word_latch #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Load,
    input  logic [15:0] Data,
    input  logic        Hold,
    input  logic        BlankEn,
    input  logic        BlinkEn,
    output logic [3:0]  Digit0,
    output logic [3:0]  Digit1,
    output logic [3:0]  Digit2,
    output logic [3:0]  Digit3,
    output logic [3:0]  Blank,
    output logic        Updated
);

    localparam int               CNT_W    = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [15:0]      word;
    logic             updated_q;
    logic [CNT_W-1:0] cnt;
    logic             phase;

    logic             load_accept;
    logic             cnt_wrap;
    logic [3:0]       lz_mask;

    // Hold freezes the register. A load is taken only when Hold is low.
    assign load_accept = Load & ~Hold;
    assign cnt_wrap    = (cnt == CNT_LAST);

    // Word capture and the one-cycle Updated pulse. Reset wins over Load.
    always_ff @(posedge Clock) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, so ordering inside the block cannot matter.
        if (Reset) begin
            word      <= 16'h0000;
            updated_q <= 1'b0;
        end else begin
            updated_q <= load_accept;
            if (load_accept) begin
                word <= Data;
            end
        end
    end

    // Blink prescaler and phase. The prescaler restarts on reset, while
    // blink is disabled, and on any accepted load. A new value therefore
    // always gets a full on-phase, and the load wins over a wrap that falls
    // on the same edge.
    always_ff @(posedge Clock) begin
        if (Reset || !BlinkEn || load_accept) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt_wrap) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

    // Leading-zero mask. Each suppressed digit requires every more
    // significant digit to be suppressed as well. Digit 0 is always shown,
    // so a word of zero still displays "0".
    always_comb begin
        // NOTE: giving every always_comb output a default first guarantees
        // it is assigned on every path, so no latch can be inferred.
        lz_mask    = 4'b0000;
        lz_mask[3] = (word[15:12] == 4'h0);
        lz_mask[2] = lz_mask[3] & (word[11:8] == 4'h0);
        lz_mask[1] = lz_mask[2] & (word[7:4] == 4'h0);
        lz_mask[0] = 1'b0;
    end

    // Blank gating. The blink off-phase blanks every digit. Otherwise the
    // leading-zero mask applies, but only when BlankEn is set.
    always_comb begin
        Blank = 4'b0000;
        if (BlinkEn && phase) begin
            Blank = 4'b1111;
        end else if (BlankEn) begin
            Blank = lz_mask;
        end
    end

    assign Digit0  = word[3:0];
    assign Digit1  = word[7:4];
    assign Digit2  = word[11:8];
    assign Digit3  = word[15:12];
    assign Updated = updated_q;

endmodule
